wb_arbiter: RTL and testbench

Write-back arbiter for the 2-way superscalar core. It sits between the three result producers and the two write ports of the 64-bit, 32-entry register file: lane-0 ALU, lane-1 ALU and the load unit. Each cycle it accepts up to two writes and removes dead writes (WAW-superseded or x0). It guarantees the two register-file ports never target the same register, and bounds starvation with per-requester wait counters.

---
 rtl/core_pkg.sv | 20 ++
 rtl/wb_pick2.sv | 35 +++
 rtl/wb_arbiter.sv | 151 +++++++++++++++
 tb/tb_wb_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core constants for the write-back path: datapath widths and
// requester indices in program order (load oldest, lane-1 youngest).
package core_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREQ = 3;

  localparam int unsigned REQ_LD = 0;
  localparam int unsigned REQ_A0 = 1;
  localparam int unsigned REQ_A1 = 2;

  localparam int unsigned WCW = 4;

  // Isolate the lowest set bit; lower index is older in program order.
  function automatic logic [NREQ-1:0] lowest_one(input logic [NREQ-1:0] v);
    return v & (~v + NREQ'(1));
  endfunction

endpackage

// File: rtl/wb_pick2.sv
// Select up to two grantees from the live requests: starved first, then the
// rest, fixed index order within each class. grant_a is the older of the pair.
module wb_pick2
  import core_pkg::*;
(
  input  logic [NREQ-1:0] live_i,
  input  logic [NREQ-1:0] starved_i,
  output logic [NREQ-1:0] grant_a_o,
  output logic [NREQ-1:0] grant_b_o
);

  logic [NREQ-1:0] sel;
  logic [1:0]      n_sel;

  always_comb begin
    sel   = '0;
    n_sel = 2'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (live_i[i] && starved_i[i] && (n_sel < 2'd2)) begin
        sel[i] = 1'b1;
        n_sel  = n_sel + 2'd1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (live_i[i] && !starved_i[i] && (n_sel < 2'd2)) begin
        sel[i] = 1'b1;
        n_sel  = n_sel + 2'd1;
      end
    end
    // Port order follows program order, not selection priority.
    grant_a_o = lowest_one(sel);
    grant_b_o = sel & ~grant_a_o;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: drops x0 and WAW-superseded writes, grants up to two
// live writes per cycle onto the two register-file ports, bounds starvation.
module wb_arbiter
  import core_pkg::*;
#(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned AW     = 5,
  parameter int unsigned STARVE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      req_killed,
  output logic                 Wen1,
  output logic [AW-1:0]        Rd_addr1,
  output logic [XLEN-1:0]      write_data1,
  output logic                 Wen2,
  output logic [AW-1:0]        Rd_addr2,
  output logic [XLEN-1:0]      write_data2
);

  localparam logic [WCW-1:0] StarveThr = WCW'(STARVE);
  localparam logic [WCW-1:0] WaitMax   = '1;

  logic [AW-1:0]   rd   [NREQ];
  logic [XLEN-1:0] data [NREQ];

  logic [NREQ-1:0] zero_kill, waw_kill, kill, live, starved;
  logic [NREQ-1:0] grant_a, grant_b, consumed;

  logic [WCW-1:0] wait_q [NREQ];
  logic [WCW-1:0] wait_d [NREQ];

  logic            wen1_q, wen1_d, wen2_q, wen2_d;
  logic [AW-1:0]   rd_addr1_q, rd_addr1_d, rd_addr2_q, rd_addr2_d;
  logic [XLEN-1:0] write_data1_q, write_data1_d, write_data2_q, write_data2_d;

  logic [AW-1:0]   a_rd, b_rd;
  logic [XLEN-1:0] a_data, b_data;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      rd[i]   = req_rd[i*AW +: AW];
      data[i] = req_data[i*XLEN +: XLEN];
    end
  end

  // A write is dead if it targets x0 or any younger pending write hits the same rd.
  always_comb begin
    zero_kill = '0;
    waw_kill  = '0;
    for (int i = 0; i < NREQ; i++) begin
      zero_kill[i] = req_valid[i] && (rd[i] == '0);
      for (int j = 0; j < NREQ; j++) begin
        if ((j > i) && req_valid[i] && req_valid[j] && (rd[i] != '0) && (rd[i] == rd[j])) begin
          waw_kill[i] = 1'b1;
        end
      end
    end
    kill = zero_kill | waw_kill;
    live = req_valid & ~kill;
    for (int i = 0; i < NREQ; i++) begin
      starved[i] = wait_q[i] >= StarveThr;
    end
  end

  wb_pick2 u_pick2 (
    .live_i    (live),
    .starved_i (starved),
    .grant_a_o (grant_a),
    .grant_b_o (grant_b)
  );

  always_comb begin
    consumed   = kill | grant_a | grant_b;
    req_ready  = consumed & {NREQ{rst_n}};
    req_killed = kill & {NREQ{rst_n}};
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && !consumed[i]) begin
        wait_d[i] = (wait_q[i] == WaitMax) ? WaitMax : wait_q[i] + WCW'(1);
      end else begin
        wait_d[i] = '0;
      end
    end
  end

  always_comb begin
    a_rd   = '0;
    a_data = '0;
    b_rd   = '0;
    b_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_a[i]) begin
        a_rd   = a_rd | rd[i];
        a_data = a_data | data[i];
      end
      if (grant_b[i]) begin
        b_rd   = b_rd | rd[i];
        b_data = b_data | data[i];
      end
    end
  end

  // Address/data only move on a grant; they are don't-care while Wen is low.
  always_comb begin
    wen1_d        = |grant_a;
    wen2_d        = |grant_b;
    rd_addr1_d    = wen1_d ? a_rd : rd_addr1_q;
    write_data1_d = wen1_d ? a_data : write_data1_q;
    rd_addr2_d    = wen2_d ? b_rd : rd_addr2_q;
    write_data2_d = wen2_d ? b_data : write_data2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen1_q        <= 1'b0;
      wen2_q        <= 1'b0;
      rd_addr1_q    <= '0;
      rd_addr2_q    <= '0;
      write_data1_q <= '0;
      write_data2_q <= '0;
      for (int i = 0; i < NREQ; i++) begin
        wait_q[i] <= '0;
      end
    end else begin
      wen1_q        <= wen1_d;
      wen2_q        <= wen2_d;
      rd_addr1_q    <= rd_addr1_d;
      rd_addr2_q    <= rd_addr2_d;
      write_data1_q <= write_data1_d;
      write_data2_q <= write_data2_d;
      for (int i = 0; i < NREQ; i++) begin
        wait_q[i] <= wait_d[i];
      end
    end
  end

  assign Wen1        = wen1_q;
  assign Rd_addr1    = rd_addr1_q;
  assign write_data1 = write_data1_q;
  assign Wen2        = wen2_q;
  assign Rd_addr2    = rd_addr2_q;
  assign write_data2 = write_data2_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: handshake outputs checked in-cycle, port
// writes checked one cycle later against a queue of expected writes.
module tb_wb_arbiter;
  import core_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [2:0]        req_valid;
  logic [3*5-1:0]    req_rd;
  logic [3*64-1:0]   req_data;
  logic [2:0]        req_ready, req_killed;
  logic              Wen1, Wen2;
  logic [4:0]        Rd_addr1, Rd_addr2;
  logic [63:0]       write_data1, write_data2;

  typedef struct {
    logic        w1;
    logic [4:0]  a1;
    logic [63:0] d1;
    logic        w2;
    logic [4:0]  a2;
    logic [63:0] d2;
  } wr_t;

  wr_t sb[$];
  int  checks   = 0;
  int  failures = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.XLEN(64), .AW(5), .STARVE(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_rd      (req_rd),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .req_killed  (req_killed),
    .Wen1        (Wen1),
    .Rd_addr1    (Rd_addr1),
    .write_data1 (write_data1),
    .Wen2        (Wen2),
    .Rd_addr2    (Rd_addr2),
    .write_data2 (write_data2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [4:0] r0, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [63:0] d0, input logic [63:0] d1,
                       input logic [63:0] d2);
    req_valid = v;
    req_rd    = {r2, r1, r0};
    req_data  = {d2, d1, d0};
  endtask

  task automatic check_port(input string tag);
    wr_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s: scoreboard empty, observed Wen1=%0b expected entry", tag, Wen1);
    end else begin
      e = sb.pop_front();
      chk({tag, " Wen1"}, 64'(Wen1), 64'(e.w1));
      if (e.w1) begin
        chk({tag, " Rd_addr1"}, 64'(Rd_addr1), 64'(e.a1));
        chk({tag, " write_data1"}, write_data1, e.d1);
      end
      chk({tag, " Wen2"}, 64'(Wen2), 64'(e.w2));
      if (e.w2) begin
        chk({tag, " Rd_addr2"}, 64'(Rd_addr2), 64'(e.a2));
        chk({tag, " write_data2"}, write_data2, e.d2);
      end
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the next one.
  task automatic step(input string tag, input logic [2:0] v,
                      input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2,
                      input logic [2:0] er, input logic [2:0] ek,
                      input logic w1, input logic [4:0] a1, input logic [63:0] x1,
                      input logic w2, input logic [4:0] a2, input logic [63:0] x2);
    wr_t e;
    drive(v, r0, r1, r2, d0, d1, d2);
    #3;
    chk({tag, " ready"}, 64'(req_ready), 64'(er));
    chk({tag, " killed"}, 64'(req_killed), 64'(ek));
    e = '{w1: w1, a1: a1, d1: x1, w2: w2, a2: a2, d2: x2};
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_port(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    drive(3'b111, 5'd1, 5'd2, 5'd3, 64'h1, 64'h2, 64'h3);
    #3;
    chk("rst ready", 64'(req_ready), 64'h0);
    chk("rst killed", 64'(req_killed), 64'h0);
    chk("rst Wen1", 64'(Wen1), 64'h0);
    chk("rst Wen2", 64'(Wen2), 64'h0);
    chk("rst Rd_addr1", 64'(Rd_addr1), 64'h0);
    chk("rst Rd_addr2", 64'(Rd_addr2), 64'h0);
    chk("rst write_data1", write_data1, 64'h0);
    chk("rst write_data2", write_data2, 64'h0);
    @(posedge clk);
    #1;
    drive(3'b000, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Dual grant, then the waiting lane-1 write on the following cycle.
    step("dual0", 3'b111, 5'd5, 5'd6, 5'd7, 64'h11, 64'h22, 64'h33, 3'b011, 3'b000,
         1'b1, 5'd5, 64'h11, 1'b1, 5'd6, 64'h22);
    step("dual1", 3'b100, 5'd5, 5'd6, 5'd7, 64'h11, 64'h22, 64'h33, 3'b100, 3'b000,
         1'b1, 5'd7, 64'h33, 1'b0, 5'd0, 64'h0);
    step("idle0", 3'b000, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 3'b000, 3'b000,
         1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);

    step("waw", 3'b110, 5'd0, 5'd9, 5'd9, 64'h0, 64'hA, 64'hB, 3'b110, 3'b010,
         1'b1, 5'd9, 64'hB, 1'b0, 5'd0, 64'h0);
    step("waw_ld", 3'b111, 5'd9, 5'd4, 5'd9, 64'h1A, 64'h2B, 64'h3C, 3'b111, 3'b001,
         1'b1, 5'd4, 64'h2B, 1'b1, 5'd9, 64'h3C);
    step("x0", 3'b100, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 64'h55, 3'b100, 3'b100,
         1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    step("x0_all", 3'b111, 5'd0, 5'd0, 5'd0, 64'h1, 64'h2, 64'h3, 3'b111, 3'b111,
         1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    step("triple", 3'b111, 5'd3, 5'd3, 5'd3, 64'h301, 64'h302, 64'h303, 3'b111, 3'b011,
         1'b1, 5'd3, 64'h303, 1'b0, 5'd0, 64'h0);

    // Lane-1 holds rd 12 while older lanes re-request; it becomes starved after 4 waits.
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) begin
        step("starve", 3'b111, 5'(20 + k), 5'(24 + k), 5'd12, 64'(100 + k), 64'(200 + k),
             64'hC, 3'b011, 3'b000, 1'b1, 5'(20 + k), 64'(100 + k), 1'b1, 5'(24 + k),
             64'(200 + k));
      end else begin
        step("starve_grant", 3'b111, 5'(20 + k), 5'(24 + k), 5'd12, 64'(100 + k),
             64'(200 + k), 64'hC, 3'b101, 3'b000, 1'b1, 5'(20 + k), 64'(100 + k), 1'b1,
             5'd12, 64'hC);
      end
    end
    step("starve_tail", 3'b010, 5'd0, 5'd28, 5'd0, 64'h0, 64'd204, 64'h0, 3'b010, 3'b000,
         1'b1, 5'd28, 64'd204, 1'b0, 5'd0, 64'h0);

    // Reset with a write just issued: ports clear immediately, nothing after release.
    step("mid", 3'b001, 5'd4, 5'd0, 5'd0, 64'h44, 64'h0, 64'h0, 3'b001, 3'b000,
         1'b1, 5'd4, 64'h44, 1'b0, 5'd0, 64'h0);
    drive(3'b010, 5'd0, 5'd8, 5'd0, 64'h0, 64'h88, 64'h0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst Wen1", 64'(Wen1), 64'h0);
    chk("mid_rst Wen2", 64'(Wen2), 64'h0);
    chk("mid_rst Rd_addr1", 64'(Rd_addr1), 64'h0);
    chk("mid_rst write_data1", write_data1, 64'h0);
    chk("mid_rst ready", 64'(req_ready), 64'h0);
    @(posedge clk);
    #1;
    chk("mid_rst hold Wen1", 64'(Wen1), 64'h0);
    drive(3'b000, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0);
    rst_n = 1'b1;
    step("post_rst", 3'b000, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 3'b000, 3'b000,
         1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
